// File: rtl/lcd_debug_pager.sv
// Debug-word pager: snapshots NUM_CHANNELS words and streams one page of them,
// MSB nibble first, into display_hex after an LCD clearAll.
module lcd_debug_pager #(
  parameter int NUM_CHANNELS      = 6,
  parameter int DATA_WIDTH        = 16,
  parameter int CHANNELS_PER_PAGE = 2,
  parameter int REFRESH_CYCLES    = 8388608,
  parameter int CLEAR_WAIT        = 100000,
  localparam int NUM_PAGES = (NUM_CHANNELS + CHANNELS_PER_PAGE - 1) / CHANNELS_PER_PAGE,
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] channel_data,
  input  logic [1:0]                         mode,
  input  logic                               step,
  input  logic                               page_next,
  input  logic                               halt,
  input  logic                               display_hex_done,
  output logic                               display_hex_start,
  output logic [3:0]                         display_hex_data_in,
  output logic                               clearAll,
  output logic [PAGE_W-1:0]                  page,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int NPC    = DATA_WIDTH / 4;
  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int NIB_W  = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int WAIT_W = $clog2(CLEAR_WAIT + 2);
  localparam int TMR_W  = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, CWAIT, SEND, GAP} state_t;

  state_t              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_new;
  logic                frame_pend_q, frame_pend_d;
  logic                page_pend_q, page_pend_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                halt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CH_W-1:0]     chan_q, chan_n, first_chan;
  logic [NIB_W-1:0]    nib_q, nib_n;
  logic                last_q, is_last;
  logic [3:0]          data_q, next_nib, first_nib;
  logic                trig, consume, tmr_expire;
  int                  last_ch;

  logic [DATA_WIDTH-1:0] snap_q [NUM_CHANNELS];

  // Snapshot is frozen for the whole frame; only the frame-start transition loads it.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_snap
    always_ff @(posedge clock) begin
      if (consume) snap_q[gi] <= channel_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    tmr_expire   = (mode == 2'd1) && (timer_q == TMR_W'(REFRESH_CYCLES - 1));
    timer_d      = (mode == 2'd1 && !tmr_expire) ? timer_q + 1'b1 : '0;
    trig         = step | page_next | tmr_expire | ((mode == 2'd2) && halt && !halt_q);
    consume      = (state_q == IDLE) && frame_pend_q;
    frame_pend_d = trig | (frame_pend_q & ~consume);
    page_pend_d  = page_next | (page_pend_q & ~consume);

    page_new = page_q;
    if (page_pend_q) page_new = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
    first_chan = CH_W'(int'(page_new) * CHANNELS_PER_PAGE);
    first_nib  = channel_data[int'(page_new)*CHANNELS_PER_PAGE*DATA_WIDTH + DATA_WIDTH - 4 +: 4];

    // Last page may be short: clamp its final channel to the ones that exist.
    last_ch = (int'(page_q) + 1) * CHANNELS_PER_PAGE;
    if (last_ch > NUM_CHANNELS) last_ch = NUM_CHANNELS;
    last_ch = last_ch - 1;
    is_last = (nib_q == '0) && (chan_q == CH_W'(last_ch));

    if (nib_q == '0) begin
      nib_n  = NIB_W'(NPC - 1);
      chan_n = chan_q + 1'b1;
    end else begin
      nib_n  = nib_q - 1'b1;
      chan_n = chan_q;
    end
    next_nib = snap_q[chan_n][int'(nib_n)*4 +: 4];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_pend_q) state_d = CLEAR;
      CLEAR:   state_d = CWAIT;
      CWAIT:   if (wait_q == '0) state_d = SEND;
      SEND:    if (display_hex_done) state_d = GAP;
      GAP:     state_d = last_q ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != IDLE);
    clearAll          = (state_q == CLEAR);
    display_hex_start = (state_q == SEND);
    frame_done        = (state_q == GAP) && last_q;
  end

  // Nibble data advances on the done edge, so it is already settled during GAP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      page_q       <= '0;
      frame_pend_q <= 1'b1;
      page_pend_q  <= 1'b0;
      timer_q      <= '0;
      halt_q       <= 1'b0;
      wait_q       <= '0;
      chan_q       <= '0;
      nib_q        <= '0;
      last_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      halt_q       <= halt;
      timer_q      <= timer_d;
      frame_pend_q <= frame_pend_d;
      page_pend_q  <= page_pend_d;
      case (state_q)
        IDLE: if (frame_pend_q) begin
          page_q <= page_new;
          chan_q <= first_chan;
          nib_q  <= NIB_W'(NPC - 1);
          last_q <= 1'b0;
          data_q <= first_nib;
        end
        CLEAR: wait_q <= WAIT_W'(CLEAR_WAIT);
        CWAIT: if (wait_q != '0) wait_q <= wait_q - 1'b1;
        SEND: if (display_hex_done) begin
          last_q <= is_last;
          if (!is_last) begin
            chan_q <= chan_n;
            nib_q  <= nib_n;
            data_q <= next_nib;
          end
        end
        default: ;
      endcase
    end
  end

  assign page                = page_q;
  assign display_hex_data_in = data_q;

endmodule

// File: tb/tb_lcd_debug_pager.sv
// Directed bench for lcd_debug_pager: 5 channels, 2 per page (3 pages),
// short clear wait and refresh period; display_hex is modelled with a 3-cycle done.
module tb_lcd_debug_pager;

  localparam int NC = 5;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   ch [NC];
  logic [NC*DW-1:0] channel_data;
  logic [1:0]    mode = 2'd0;
  logic          step = 1'b0, page_next = 1'b0, halt = 1'b0, done = 1'b0;
  logic          start, clear_all, busy, frame_done;
  logic [3:0]    data_in;
  logic [1:0]    page;

  int checks = 0, errors = 0;
  int cyc = 0, clr_cnt = 0, fd_cnt = 0, viol = 0, rcnt = 0;
  int clr_times[$];
  logic [3:0] nibq[$];
  logic       prev_start = 1'b0;
  logic [3:0] prev_data = 4'h0;

  assign channel_data = {ch[4], ch[3], ch[2], ch[1], ch[0]};

  always #5 clock = ~clock;

  lcd_debug_pager #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .CHANNELS_PER_PAGE(2),
    .REFRESH_CYCLES(2000), .CLEAR_WAIT(10)
  ) dut (
    .clock(clock), .reset(reset), .channel_data(channel_data), .mode(mode),
    .step(step), .page_next(page_next), .halt(halt), .display_hex_done(done),
    .display_hex_start(start), .display_hex_data_in(data_in), .clearAll(clear_all),
    .page(page), .busy(busy), .frame_done(frame_done)
  );

  // display_hex model: done pulses 3 cycles after start rises; records each nibble.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        done = 1'b0; rcnt = 0;
      end else if (done) begin
        done = 1'b0; rcnt = 0;
      end else if (start) begin
        rcnt++;
        if (rcnt == 3) begin
          done = 1'b1;
          nibq.push_back(data_in);
          $display("[%0d] nibble %h page %0d", cyc, data_in, page);
        end
      end else rcnt = 0;
    end
  end

  always @(posedge clock) begin
    #1;
    cyc++;
    if (clear_all) begin clr_cnt++; clr_times.push_back(cyc); end
    if (frame_done) fd_cnt++;
    if (prev_start && start && data_in !== prev_data) viol++;
    prev_start = start;
    prev_data  = data_in;
  end

  task automatic wait_frame(input int budget, output bit ok);
    int fd0;
    fd0 = fd_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (fd_cnt != fd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clock);
    if (which == 0) step = 1'b1; else page_next = 1'b1;
    @(negedge clock);
    step = 1'b0; page_next = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [31:0] exp, input int exp_n,
                             input logic [1:0] exp_page);
    logic [31:0] got;
    got = '0;
    foreach (nibq[k]) got = {got[27:0], nibq[k]};
    checks++;
    if (nibq.size() != exp_n || got !== exp) begin
      errors++;
      $display("FAIL %s stream: got %0d nibbles %h, expected %0d nibbles %h", name, nibq.size(), got, exp_n, exp);
    end
    checks++;
    if (page !== exp_page) begin
      errors++;
      $display("FAIL %s page: got %0d expected %0d", name, page, exp_page);
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clock);
    checks++;
    if ({start, clear_all, busy, frame_done, page, data_in} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b clr=%b busy=%b fd=%b page=%0d data=%h, expected all 0",
               start, clear_all, busy, frame_done, page, data_in);
    end
    nibq.delete();
    clr_cnt = 0;
    reset = 1'b0;
    wait_frame(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_autoframe: frame_done seen %b expected 1", ok); end
    checks++;
    if (clr_cnt != 1) begin errors++; $display("FAIL reset_clear: got %0d clearAll pulses expected 1", clr_cnt); end
    check_frame("reset_frame", 32'h1234ABCD, 8, 2'd0);
    repeat (150) @(negedge clock);
    checks++;
    if (clr_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_retrigger: got clr=%0d busy=%b expected clr=1 busy=0", clr_cnt, busy);
    end
  endtask

  task automatic test_page_cycle();
    bit ok;
    nibq.delete(); pulse(1); wait_frame(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL page1_done: got %b expected 1", ok); end
    check_frame("page1", 32'h00FF8001, 8, 2'd1);
    nibq.delete(); pulse(1); wait_frame(500, ok);
    check_frame("page2_short", 32'h0000BEEF, 4, 2'd2);
    nibq.delete(); pulse(1); wait_frame(500, ok);
    check_frame("page_wrap", 32'h1234ABCD, 8, 2'd0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c0, n;
    c0 = clr_cnt;
    pulse(0);
    n = 0;
    while (frame_done !== 1'b1 && n < 500) begin @(negedge clock); n++; end
    checks++;
    if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_first: frame_done %b expected 1", frame_done); end
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    wait_frame(500, ok);
    checks++;
    if (!ok || clr_cnt - c0 != 2) begin
      errors++;
      $display("FAIL b2b_retained: got %0d frames (done=%b) expected 2", clr_cnt - c0, ok);
    end
  endtask

  task automatic test_continuous();
    bit ok;
    int n;
    clr_times.delete();
    @(negedge clock);
    mode = 2'd1;
    n = 0;
    while (clr_times.size() < 1 && n < 2100) begin @(negedge clock); n++; end
    nibq.delete();
    ch[0] = 16'h5678;
    wait_frame(500, ok);
    check_frame("cont_snapshot", 32'h1234ABCD, 8, 2'd0);
    nibq.delete();
    wait_frame(2500, ok);
    check_frame("cont_newval", 32'h5678ABCD, 8, 2'd0);
    n = 0;
    while (clr_times.size() < 3 && n < 2500) begin @(negedge clock); n++; end
    checks++;
    if (clr_times.size() < 3 || clr_times[1] - clr_times[0] != 2000 || clr_times[2] - clr_times[1] != 2000) begin
      errors++;
      $display("FAIL cont_spacing: got %0d starts, gaps %0d/%0d expected 2000/2000", clr_times.size(),
               clr_times.size() > 1 ? clr_times[1] - clr_times[0] : -1,
               clr_times.size() > 2 ? clr_times[2] - clr_times[1] : -1);
    end
    mode = 2'd0;
    n = 0;
    while (busy && n < 500) begin @(negedge clock); n++; end
  endtask

  task automatic test_halt_collapse();
    bit ok;
    int fd0, n;
    mode = 2'd2;
    fd0 = fd_cnt;
    pulse(0);
    n = 0;
    while (!busy && n < 20) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    halt = 1'b1;
    repeat (3) pulse(0);
    repeat (2) pulse(1);
    wait_frame(500, ok);
    nibq.delete();
    wait_frame(500, ok);
    check_frame("halt_extra", 32'h00FF8001, 8, 2'd1);
    repeat (200) @(negedge clock);
    checks++;
    if (fd_cnt - fd0 != 2) begin
      errors++;
      $display("FAIL halt_collapse: got %0d frames expected 2", fd_cnt - fd0);
    end
    halt = 1'b0;
    mode = 2'd0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int n, c0;
    nibq.delete();
    pulse(0);
    n = 0;
    do begin @(posedge clock); #2; n++; end
    while (!(nibq.size() == 5 && start && !done) && n < 500);
    checks++;
    if (!(nibq.size() == 5 && start)) begin
      errors++;
      $display("FAIL midframe_reach: got %0d nibbles start=%b expected 5 and 1", nibq.size(), start);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (start !== 1'b0 || clear_all !== 1'b0 || busy !== 1'b0 || page !== 2'd0) begin
      errors++;
      $display("FAIL midframe_async: got start=%b clr=%b busy=%b page=%0d expected 0", start, clear_all, busy, page);
    end
    repeat (3) @(negedge clock);
    nibq.delete();
    c0 = clr_cnt;
    reset = 1'b0;
    wait_frame(500, ok);
    checks++;
    if (!ok || clr_cnt - c0 != 1) begin
      errors++;
      $display("FAIL midframe_restart: got done=%b clears=%0d expected 1/1", ok, clr_cnt - c0);
    end
    check_frame("midframe_fresh", 32'h5678ABCD, 8, 2'd0);
  endtask

  initial begin
    ch[0] = 16'h1234; ch[1] = 16'hABCD; ch[2] = 16'h00FF; ch[3] = 16'h8001; ch[4] = 16'hBEEF;
    test_reset();
    test_page_cycle();
    test_back_to_back();
    test_continuous();
    test_halt_collapse();
    test_reset_midframe();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL data_stable: got %0d changes while start=1 expected 0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_debug_pager.md
Name: lcd_debug_pager

Overview:
- Parametrised successor to the fixed-width CPU-state LCD display sequencer.
- Snapshots NUM_CHANNELS debug words and streams one page of them, nibble by nibble, into display_hex over its start/done handshake. Issues clearAll before each frame.
- Three trigger modes: single-step, timed continuous refresh, and halt-edge. A page_next button cycles pages.
- Sits in the debug top level between the CPU/peripheral debug taps and display_hex/lcd_control.

Parameters:
- NUM_CHANNELS, 6, number of debug words on channel_data.
- DATA_WIDTH, 16, bits per channel; must be a multiple of 4.
- CHANNELS_PER_PAGE, 2, channels shown per frame.
- REFRESH_CYCLES, 8388608, clock cycles between frame starts in continuous mode.
- CLEAR_WAIT, 100000, cycles to wait after the clearAll pulse before the first nibble.

Ports:
- clock  in  1  system clock (33 MHz domain).
- reset  in  1  asynchronous, active-high.
- channel_data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- mode  in  2  0=single-step, 1=continuous, 2=halt-triggered, 3=treated as 0.
- step  in  1  one-cycle pulse from the debounced button; requests a frame.
- page_next  in  1  one-cycle pulse; advance page and redraw.
- halt  in  1  CPU halt level.
- display_hex_done  in  1  one-cycle pulse: the current nibble has been written.
- display_hex_start  out  1  nibble request, held high until done.
- display_hex_data_in  out  4  nibble value.
- clearAll  out  1  one-cycle LCD clear pulse.
- page  out  clog2(NUM_PAGES) (min 1)  page currently displayed.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse after the last nibble of a frame.

Behaviour:

Reset values and page geometry:
- Reset is asynchronous. It clears:
  - state to IDLE;
  - page, display_hex_start, display_hex_data_in, clearAll, frame_done to 0;
  - the refresh timer to 0;
  - the page_pending flag to 0.
- Reset sets the frame-pending flag to 1, so a frame starts automatically after reset.
- NUM_PAGES = ceil(NUM_CHANNELS / CHANNELS_PER_PAGE).
- Page p shows channels p*CPP .. min((p+1)*CPP, NUM_CHANNELS)-1, in ascending index.
- The last page shows only the channels that exist; there is no padding.
- Within a channel, nibbles go MSB first: DATA_WIDTH/4 nibbles per channel.

FSM states:
- IDLE:
  - If frame-pending: apply any page_pending increment (page wraps NUM_PAGES-1 -> 0), then clear both pending flags.
  - In the same transition, snapshot all of channel_data into an internal register, reset the nibble counter, and go to CLEAR.
- CLEAR: assert clearAll for exactly 1 cycle, load the wait counter with CLEAR_WAIT, go to CWAIT.
- CWAIT: count down; at 0 go to SEND.
- SEND:
  - Hold display_hex_start=1 and display_hex_data_in = the snapshot nibble for the current index.
  - On display_hex_done: deassert start next cycle and go to GAP.
- GAP:
  - Exactly 1 cycle with start=0.
  - Increment the nibble index. If it was the last nibble of the page, pulse frame_done and go to IDLE; otherwise go to SEND.
- Nibble output changes only in GAP/IDLE, never while start=1.
- The snapshot is immutable during a frame, so changes on channel_data mid-frame do not affect the frame being displayed.

Trigger rules (evaluated every cycle in every state; each sets frame-pending):
- mode 0/3: step.
- mode 1: step, or refresh timer expiry.
  - The timer counts every cycle while mode=1 and wraps at REFRESH_CYCLES-1.
  - The timer is held at 0 in other modes.
- mode 2: step, or halt rising edge (halt registered one cycle).
- All modes: page_next sets frame-pending and page_pending.

Pending-flag and boundary rules:
- Pending flags are one-deep; multiple events during a frame collapse into one redraw after frame_done.
- Multiple page_next pulses during one frame advance the page by 1 only.
- step and page_next in the same cycle produce one frame with the page advanced.
- A trigger arriving in the same cycle as frame_done is retained: IDLE starts the next frame one cycle later.
- NUM_PAGES=1: page stays 0 and page_next still forces a redraw.
- Reset mid-frame: start and clearAll drop immediately (asynchronous). A fresh frame then starts on page 0.

Test Plan:
1. Reset with defaults, channel_data ch0=16'h1234, ch1=16'hABCD, mode=0; display_hex_done pulses 3 cycles after each start rise.
   - Required: one clearAll pulse, then the nibble stream 1,2,3,4,A,B,C,D, then frame_done; page=0; no further frame without step.
2. page_next pulse with ch2=16'h00FF, ch3=16'h8001.
   - Required: page=1, stream 0,0,F,F,8,0,0,1.
   - After two more pulses: page wraps 2 -> 0.
3. NUM_CHANNELS=5, CPP=2, navigate to page 2 with ch4=16'hBEEF.
   - Required: exactly 4 nibbles B,E,E,F, then frame_done.
4. mode=1, REFRESH_CYCLES=2000, CLEAR_WAIT=10.
   - Required: frame starts spaced exactly 2000 cycles.
   - Changing ch0 mid-frame: displayed nibbles match the value at frame start.
5. mode=2: halt rises mid-frame, and 3 step pulses plus 2 page_next pulses are also issued in that frame.
   - Required: exactly one extra frame after frame_done, with the page advanced by 1.
6. Assert reset while display_hex_start=1 at nibble 5.
   - Required: start=0 in the same cycle.
   - After release: clearAll, then a fresh frame from nibble 0 on page 0.
